// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, single-bus arbiter with round-robin grant and a
// per-transaction timeout.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   m{0,1}_req/addr/wdata/we   master request (m0 = CPU, m1 = DMA)
//   m{0,1}_ack/err/rdata       one-cycle completion pulse, error flag, read data
//   bAddr/bWData/bWE/bStb      shared-bus request, held for the whole BUSY phase
//   bRData/bAck                selected slave's read data and completion
//
// Transaction timeline: req sampled in IDLE (cycle 0), bStb high from cycle 1,
// bAck in cycle k, ack in cycle k+1, back in IDLE in cycle k+2.
// All outputs come straight from flops.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16  // BUSY cycles allowed without bAck (2..255)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] bAddr,
  output logic [31:0] bWData,
  output logic        bWE,
  output logic        bStb,
  input  logic [31:0] bRData,
  input  logic        bAck
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q;
  logic        last_q;   // master granted most recently
  logic        gnt_q;    // master owning the current transaction
  logic [7:0]  cnt_q;    // BUSY cycle index, 0 on the first BUSY cycle
  logic        gnt_d;

  // Tie goes to the master not granted last; a lone requester always wins.
  always_comb begin
    gnt_d = m1_req;
    if (m0_req && m1_req) gnt_d = ~last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      bStb     <= 1'b0;
      bWE      <= 1'b0;
      bAddr    <= '0;
      bWData   <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            bAddr   <= gnt_d ? m1_addr  : m0_addr;
            bWData  <= gnt_d ? m1_wdata : m0_wdata;
            bWE     <= gnt_d ? m1_we    : m0_we;
            bStb    <= 1'b1;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // An ack in the last allowed cycle still wins over the timeout.
          if (bAck || (cnt_q == 8'(TIMEOUT - 1))) begin
            bStb    <= 1'b0;
            bWE     <= 1'b0;
            state_q <= RESP;
            if (gnt_q) begin
              m1_ack   <= 1'b1;
              m1_err   <= ~bAck;
              m1_rdata <= bAck ? bRData : 32'h0;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= ~bAck;
              m0_rdata <= bAck ? bRData : 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          // Single-cycle response; requests are not looked at here.
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          m0_err  <= 1'b0;
          m1_err  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected transactions,
// a negedge monitor checks bus contents and responses against the queue.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bAddr, bWData, bRData;
  logic        bWE, bStb, bAck;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bAddr(bAddr), .bWData(bWData), .bWE(bWE), .bStb(bStb),
    .bRData(bRData), .bAck(bAck)
  );

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          busy;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          slave_lat = 1;      // BUSY cycle in which the slave acks, 0 = never
  logic [31:0] slave_rdata = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave: acks in BUSY cycle slave_lat, counting from 1.
  initial begin
    int scnt;
    scnt = 0;
    bAck = 1'b0;
    bRData = '0;
    forever begin
      tick();
      if (bStb) scnt++;
      else scnt = 0;
      bAck = bStb && (scnt == slave_lat);
      bRData = slave_rdata;
    end
  end

  // Monitor: bus contents while bStb, response on ack, rdata hold otherwise.
  initial begin
    int          busy;
    logic [31:0] last0, last1;
    exp_t        e;
    busy = 0; last0 = '0; last1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; last0 = '0; last1 = '0;
      end else begin
        if (bStb) begin
          busy++;
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_unexpected: bStb high with addr %h, no transaction expected", bAddr);
          end else begin
            chk("bAddr", bAddr, q[0].addr);
            chk("bWData", bWData, q[0].wdata);
            chk("bWE", 32'(bWE), 32'(q[0].we));
          end
        end
        if (m0_ack || m1_ack) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL ack_unexpected: acks %b%b, none expected", m1_ack, m0_ack);
          end else begin
            e = q.pop_front();
            chk("ack_master", {30'd0, m1_ack, m0_ack}, e.m ? 32'd2 : 32'd1);
            chk("err", 32'(e.m ? m1_err : m0_err), 32'(e.err));
            chk("other_err", 32'(e.m ? m0_err : m1_err), 32'd0);
            chk("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
            chk("busy_cycles", busy, e.busy);
            chk("bStb_in_resp", 32'(bStb), 32'd0);
            if (e.m) last1 = e.rdata;
            else last0 = e.rdata;
          end
          busy = 0;
        end
        if (!m0_ack) chk("m0_rdata_hold", m0_rdata, last0);
        if (!m1_ack) chk("m1_rdata_hold", m1_rdata, last1);
      end
    end
  end

  task automatic push(bit m, bit we, logic [31:0] addr, logic [31:0] wdata,
                      bit err, logic [31:0] rdata, int busy);
    exp_t e;
    e = '{m: m, we: we, addr: addr, wdata: wdata, err: err, rdata: rdata, busy: busy};
    q.push_back(e);
  endtask

  // Single-master transaction issued from IDLE; checks req-to-ack latency.
  task automatic txn(bit m, bit we, logic [31:0] addr, logic [31:0] wdata,
                     int lat, logic [31:0] rd, bit exp_err, logic [31:0] exp_rd,
                     int exp_busy);
    int n;
    bit done;
    push(m, we, addr, wdata, exp_err, exp_rd, exp_busy);
    slave_lat = lat;
    slave_rdata = rd;
    if (m) begin m1_addr = addr; m1_wdata = wdata; m1_we = we; m1_req = 1'b1; end
    else   begin m0_addr = addr; m0_wdata = wdata; m0_we = we; m0_req = 1'b1; end
    n = 0; done = 0;
    while (!done && n < 60) begin
      tick();
      n++;
      if (m ? m1_ack : m0_ack) done = 1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("latency", n, exp_busy + 1);
    tick();
  endtask

  // Both masters hold req until nacks responses have been seen.
  task automatic both(int nacks);
    int k, n;
    k = 0; n = 0;
    m0_req = 1'b1; m1_req = 1'b1;
    while (k < nacks && n < 100) begin
      tick();
      n++;
      if (m0_ack || m1_ack) k++;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("pair_acks", k, nacks);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    tick(); tick(); tick();
    // Reset state.
    chk("rst_bStb", 32'(bStb), 0);
    chk("rst_bWE", 32'(bWE), 0);
    chk("rst_bAddr", bAddr, 0);
    chk("rst_bWData", bWData, 0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 0);
    chk("rst_errs", {30'd0, m1_err, m0_err}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);

    // Both requesting from reset: m0, m1, m0, m1.
    m0_addr = 32'h0000_0100; m0_we = 0; m0_wdata = '0;
    m1_addr = 32'h0000_0200; m1_we = 1; m1_wdata = 32'h0000_0055;
    slave_lat = 1; slave_rdata = 32'h1111_0000;
    push(0, 0, 32'h100, 32'h0,  0, 32'h1111_0000, 1);
    push(1, 1, 32'h200, 32'h55, 0, 32'h1111_0000, 1);
    push(0, 0, 32'h100, 32'h0,  0, 32'h1111_0000, 1);
    push(1, 1, 32'h200, 32'h55, 0, 32'h1111_0000, 1);
    m0_req = 1'b1; m1_req = 1'b1;
    rst = 1'b0;
    both(4);

    // m0 read, ack in 2nd BUSY cycle -> response in cycle 3.
    txn(0, 0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 2);
    // m1 write held stable until ack.
    txn(1, 1, 32'h0000_7F04, 32'h0000_00A5, 4, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 4);
    // No ack: 16 BUSY cycles, err=1, rdata forced to 0.
    txn(0, 0, 32'h0000_0020, 32'h0, 0, 32'h1234_5678, 1, 32'h0, 16);
    // Ack in the timeout cycle counts as a normal ack.
    txn(1, 0, 32'h0000_0030, 32'h0, 16, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 16);

    // Reset mid-BUSY aborts without ack and restores the pointer to m1.
    slave_lat = 0;
    push(0, 0, 32'h0000_0300, 32'h0, 0, 32'h0, 0);
    m0_addr = 32'h0000_0300; m0_we = 0; m0_wdata = '0; m0_req = 1'b1;
    tick(); tick(); tick();
    chk("abort_bStb_before", 32'(bStb), 1);
    rst = 1'b1; m0_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_bStb", 32'(bStb), 0);
    chk("abort_acks", {30'd0, m1_ack, m0_ack}, 0);
    void'(q.pop_front());
    repeat (4) tick();

    // Tie after reset goes to m0 first.
    m0_addr = 32'h0000_0400; m0_we = 0; m0_wdata = '0;
    m1_addr = 32'h0000_0500; m1_we = 0; m1_wdata = '0;
    slave_lat = 1; slave_rdata = 32'h7777_0001;
    push(0, 0, 32'h400, 32'h0, 0, 32'h7777_0001, 1);
    push(1, 0, 32'h500, 32'h0, 0, 32'h7777_0001, 1);
    both(2);

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 16, meaning the number of BUSY cycles allowed without bAck before an error is returned (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports m0_req (in, 1), m0_addr (in, 32), m0_wdata (in, 32) and m0_we (in, 1): master 0 (CPU) request, address, write data and write enable.
REQ-005 The block SHALL have ports m0_ack (out, 1), m0_err (out, 1) and m0_rdata (out, 32): master 0 completion pulse, error flag and read data.
REQ-006 The block SHALL have ports m1_req, m1_addr, m1_wdata, m1_we, m1_ack, m1_err and m1_rdata, identical to the master 0 set, for master 1 (DMA).
REQ-007 The block SHALL have ports bAddr (out, 32), bWData (out, 32), bWE (out, 1) and bStb (out, 1): shared-bus address, write data, write enable and transaction strobe, with bAddr feeding the existing address decoder.
REQ-008 The block SHALL have ports bRData (in, 32) and bAck (in, 1): read data and completion from the selected slave.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-010 In IDLE, if no req is high, the FSM SHALL stay in IDLE.
REQ-011 In IDLE, if any req is high, the FSM SHALL grant one master, latch that master's addr, wdata and we into the bus registers, and go to BUSY on the next edge.
REQ-012 Arbitration SHALL be round-robin: on a simultaneous request, the master not granted last wins; a single requester always wins.
REQ-013 The last-grant pointer SHALL reset to master 1, so master 0 wins the first tie after reset.
REQ-014 In BUSY, bStb SHALL be 1, and bAddr, bWData and bWE SHALL hold the latched values, stable for the whole transaction.
REQ-015 In BUSY, requester input changes SHALL have no effect on the bus outputs.
REQ-016 In BUSY, on bAck=1 the FSM SHALL capture bRData and go to RESP with err=0.
REQ-017 A BUSY cycle counter SHALL start at 0 on entry to BUSY.
REQ-018 If the counter reaches TIMEOUT-1 with bAck=0, the FSM SHALL go to RESP with err=1 and rdata=0.
REQ-019 If bAck=1 in the timeout cycle, the transaction SHALL be treated as a normal ack (err=0).
REQ-020 In RESP, the granted master's ack SHALL be 1 for exactly one cycle, with its err and rdata valid in that same cycle.
REQ-021 In RESP, the other master's ack and err SHALL be 0, and bStb SHALL be 0.
REQ-022 RESP SHALL always go to IDLE, and all req inputs SHALL be ignored in RESP.
REQ-023 A master SHALL drop req in the cycle it sees ack; a req still high in the following IDLE cycle is a new transaction.
REQ-024 m*_rdata SHALL hold its last value until the next RESP for that master.
REQ-025 Latency SHALL be: req sampled in IDLE (cycle 0), bStb high from cycle 1, bAck in cycle k (k≥1), ack in cycle k+1, IDLE in cycle k+2.
REQ-026 Minimum transaction length (bAck in cycle 1) SHALL be 3 cycles, IDLE to IDLE.
REQ-027 bAck while not in BUSY SHALL be ignored.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While rst=1 at an edge, the state SHALL go to IDLE, the pointer to master 1 and the counter to 0.
REQ-030 While rst=1 at an edge, bStb, bWE, m0_ack, m1_ack, m0_err and m1_err SHALL go to 0.
REQ-031 While rst=1 at an edge, bAddr, bWData, m0_rdata and m1_rdata SHALL go to 0.
REQ-032 Reset asserted in BUSY or RESP SHALL abort the transaction with no ack issued, and bStb SHALL be 0 in the cycle after the reset edge.

Verification
REQ-033 The bench SHALL cover: m0 read, addr 0x00000010, slave bAck at 2nd BUSY cycle with bRData 0xDEADBEEF -> m0_ack=1, m0_err=0, m0_rdata 0xDEADBEEF in cycle 3, m1_ack=0.
REQ-034 The bench SHALL cover: m0 and m1 both requesting continuously from reset -> grant order m0, m1, m0, m1, with bAddr alternating between their addresses.
REQ-035 The bench SHALL cover: m1 write, addr 0x00007F04, wdata 0x000000A5 -> bWE=1, bAddr 0x00007F04, bWData 0xA5 held stable for all BUSY cycles until bAck.
REQ-036 The bench SHALL cover: bAck never asserted, TIMEOUT=16 -> exactly 16 BUSY cycles, then ack=1, err=1, rdata=0, then IDLE.
REQ-037 The bench SHALL cover: bAck exactly in BUSY cycle 16 -> err=0 and data captured.
REQ-038 The bench SHALL cover: rst pulsed in mid-BUSY -> next cycle bStb=0 and no ack; the pointer is restored, so a later tie is won by m0.
